// File: rtl/present_round_ctrl.sv
//==============================================================================
// Module      : present_round_ctrl
// Description : Iterative PRESENT-80 encryption engine with a time-multiplexed
//               S-layer and a dedicated key-schedule S-box.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module present_round_ctrl #(
    parameter int SBOX_LANES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ciphertext,
    output logic        busy
);

    localparam int GROUPS = 16 / SBOX_LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] c_last_grp = GW'(GROUPS - 1);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_ark  = 3'd1;
    localparam logic [2:0] c_sub  = 3'd2;
    localparam logic [2:0] c_perm = 3'd3;
    localparam logic [2:0] c_done = 3'd4;

    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
              SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
            $error("present_round_ctrl: SBOX_LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    function automatic logic [3:0] present_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    logic [2:0]    r_fsm;
    logic [63:0]   r_state;
    logic [79:0]   r_key;
    logic [5:0]    r_round;
    logic [GW-1:0] r_grp;

    logic [3:0]  w_lane_in  [SBOX_LANES];
    logic [3:0]  w_lane_out [SBOX_LANES];
    logic [63:0] w_state_sub;
    logic [63:0] w_state_perm;
    logic [79:0] w_key_rot;
    logic [79:0] w_key_next;

    // Lane l of group g always handles nibble g*SBOX_LANES + l.
    generate
        for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
            assign w_lane_in[l]  = r_state[(int'(r_grp) * SBOX_LANES + l) * 4 +: 4];
            assign w_lane_out[l] = present_sbox(w_lane_in[l]);
        end
    endgenerate

    always_comb begin
        w_state_sub = r_state;
        for (int l = 0; l < SBOX_LANES; l++) begin
            w_state_sub[(int'(r_grp) * SBOX_LANES + l) * 4 +: 4] = w_lane_out[l];
        end
    end

    always_comb begin
        w_state_perm = r_state;
        for (int i = 0; i < 63; i++) begin
            w_state_perm[(16 * i) % 63] = r_state[i];
        end
    end

    assign w_key_rot = {r_key[18:0], r_key[79:19]};

    always_comb begin
        w_key_next          = w_key_rot;
        w_key_next[79:76]   = present_sbox(w_key_rot[79:76]);
        w_key_next[19:15]   = w_key_rot[19:15] ^ r_round[4:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= c_idle;
            r_state <= '0;
            r_key   <= '0;
            r_round <= 6'd1;
            r_grp   <= '0;
        end else begin
            case (r_fsm)
                c_idle: begin
                    if (in_valid) begin
                        r_state <= plaintext;
                        r_key   <= key;
                        r_round <= 6'd1;
                        r_fsm   <= c_ark;
                    end
                end
                c_ark: begin
                    r_state <= r_state ^ r_key[79:16];
                    if (r_round == 6'd32) begin
                        r_fsm <= c_done;
                    end else begin
                        r_grp <= '0;
                        r_fsm <= c_sub;
                    end
                end
                c_sub: begin
                    r_state <= w_state_sub;
                    if (r_grp == c_last_grp) begin
                        r_fsm <= c_perm;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                c_perm: begin
                    r_state <= w_state_perm;
                    r_key   <= w_key_next;
                    r_round <= r_round + 6'd1;
                    r_fsm   <= c_ark;
                end
                c_done: begin
                    if (out_ready) begin
                        r_fsm <= c_idle;
                    end
                end
                default: r_fsm <= c_idle;
            endcase
        end
    end

    assign in_ready   = (r_fsm == c_idle);
    assign out_valid  = (r_fsm == c_done);
    assign busy       = (r_fsm != c_idle);
    // Intermediate round state is never exposed on the output bus.
    assign ciphertext = out_valid ? r_state : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_present_round_ctrl.sv
//==============================================================================
// Module      : tb_present_round_ctrl
// Description : Self-checking bench for present_round_ctrl (16-lane and 1-lane).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_present_round_ctrl;

    localparam int LAT16 = 31 * (16 / 16 + 2) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        in_ready, out_valid, busy;
    logic [63:0] ciphertext;

    logic        in_valid1, out_ready1;
    logic [63:0] plaintext1;
    logic [79:0] key1;
    logic        in_ready1, out_valid1, busy1;
    logic [63:0] ciphertext1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    present_round_ctrl #(.SBOX_LANES(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
    );

    present_round_ctrl #(.SBOX_LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .plaintext(plaintext1), .key(key1), .out_valid(out_valid1),
        .out_ready(out_ready1), .ciphertext(ciphertext1), .busy(busy1)
    );

    int sbox_t [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    // Straight algorithmic PRESENT-80 reference.
    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] k_in);
        logic [63:0] s, t;
        logic [79:0] k;
        logic [4:0]  rc;
        s = pt;
        k = k_in;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sbox_t[s[4*n +: 4]]);
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s = t;
            k = {k[18:0], k[79:19]};
            k[79:76] = 4'(sbox_t[k[79:76]]);
            rc = 5'(r);
            k[19:15] = k[19:15] ^ rc;
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: 0 idle, 1 running (countdown), 2 result held.
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [63:0] m_ct    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_ct    <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_phase <= 1;
                    m_cnt   <= LAT16;
                    m_ct    <= present_enc(plaintext, key);
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cmp_in_ready",  80'(in_ready),  80'(rst || m_phase == 0));
        check("cmp_out_valid", 80'(out_valid), 80'(!rst && m_phase == 2));
        check("cmp_busy",      80'(busy),      80'(!rst && m_phase != 0));
        if (rst)               check("cmp_ct_reset", 80'(ciphertext), 80'd0);
        else if (m_phase == 2) check("cmp_ct",       80'(ciphertext), 80'(m_ct));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input logic [63:0] pt, input logic [79:0] k,
                           input logic [63:0] exp_ct, input bit toggle, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        check("accept_ready", 80'(in_ready), 80'd1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        n = 0;
        while (!out_valid && n < 2000) begin
            if (toggle) begin
                in_valid  = ~in_valid;
                plaintext = plaintext ^ 64'hA5A5_5A5A_0F0F_F0F0;
                key       = ~key;
            end
            step();
            n++;
        end
        in_valid = 1'b0;
        check("latency", 80'(n), 80'd94);
        check("ciphertext", 80'(ciphertext), 80'(exp_ct));
        for (int h = 0; h < hold; h++) begin
            plaintext = plaintext + 64'd1;
            check("hold_in_ready",  80'(in_ready),   80'd0);
            check("hold_out_valid", 80'(out_valid),  80'd1);
            check("hold_ct",        80'(ciphertext), 80'(exp_ct));
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_out_valid", 80'(out_valid), 80'd0);
        check("post_in_ready",  80'(in_ready),  80'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; plaintext1 = '0; key1 = '0;
        repeat (3) step();
        check("rst_in_ready",   80'(in_ready),    80'd1);
        check("rst_out_valid",  80'(out_valid),   80'd0);
        check("rst_busy",       80'(busy),        80'd0);
        check("rst_ct",         80'(ciphertext),  80'd0);
        check("rst1_in_ready",  80'(in_ready1),   80'd1);
        check("rst1_busy",      80'(busy1),       80'd0);
        rst = 1'b0;
        step();

        check("model_v1", 80'(present_enc(64'd0, 80'd0)), 80'h5579C1387B228445);
        check("model_v2", 80'(present_enc(64'd0, {80{1'b1}})), 80'hE72C46C0F5945049);
        check("model_v3", 80'(present_enc({64{1'b1}}, 80'd0)), 80'hA112FFC72F68417B);
        check("model_v4", 80'(present_enc({64{1'b1}}, {80{1'b1}})), 80'h3333DCD3213210D2);

        run_vec(64'd0,      80'd0,      64'h5579C1387B228445, 1'b0, 0);
        run_vec(64'd0,      {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0, 0);
        run_vec({64{1'b1}}, 80'd0,      64'hA112FFC72F68417B, 1'b0, 0);
        run_vec({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, 0);
        run_vec(64'd0,      80'd0,      64'h5579C1387B228445, 1'b1, 10);

        // Abort an encryption around round 15, then run a fresh block.
        plaintext = 64'd0; key = 80'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (45) step();
        check("mid_busy", 80'(busy), 80'd1);
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("mid_rst_in_ready",  80'(in_ready),   80'd1);
            check("mid_rst_out_valid", 80'(out_valid),  80'd0);
            check("mid_rst_busy",      80'(busy),       80'd0);
            check("mid_rst_ct",        80'(ciphertext), 80'd0);
            step();
        end
        rst = 1'b0;
        step();
        run_vec({64{1'b1}}, 80'd0, 64'hA112FFC72F68417B, 1'b0, 0);

        // Single-lane instance: same result, longer latency.
        plaintext1 = {64{1'b1}}; key1 = {80{1'b1}}; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 1000) begin step(); n++; end
        check("l1_latency", 80'(n), 80'd559);
        check("l1_ct", 80'(ciphertext1), 80'h3333DCD3213210D2);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("l1_in_ready", 80'(in_ready1), 80'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
